mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the single 8 x 256-bit matrix memory between two requesters (req0 = EXE operand fetch,
//  req1 = ALU result writeback). Round-robin arbitration, one access in flight, drives memory
//  address/strobes/write data, captures read data, returns a one-cycle response to the winner.
// PARAMETERS
//  DATA_W     256    memory word width (bits)
//  MEM_AW     4      requester address width (memory field addressBus[7:4])
//  MEM_DEPTH  8      implemented memory words; valid addresses 0..MEM_DEPTH-1
//  MODULE_ID  4'h1   module-select code placed on addressBus[15:12] during a strobe
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  reset        in   1       synchronous, active-low reset
//  req_valid    in   2       per-requester request; hold with fields stable until req_ready
//  req_write    in   2       1 = write, 0 = read
//  req_addr     in   2xMEM_AW per-requester word address
//  req_wdata    in   2xDATA_W per-requester write data
//  req_ready    out  2       one-hot accept pulse, one cycle
//  rsp_valid    out  2       one-hot completion pulse, one cycle
//  rsp_rdata    out  DATA_W  read data, valid with rsp_valid (held until next response)
//  rsp_err      out  1       out-of-range error, valid with rsp_valid
//  addressBus   out  16      {MODULE_ID, 4'h0, addr, 4'h0} during ISSUE, else 16'h0000
//  writeToMem   out  1       memory write strobe
//  readFromMem  out  1       memory read strobe
//  inputDataBus out  DATA_W  write data to memory
//  outputDataBus in  DATA_W  read data from memory (valid cycle after read strobe)
//  busy         out  1       high in any state but IDLE
// BEHAVIOUR
//  - All outputs registered. Reset (reset==0 at posedge): state IDLE, all strobes/pulses 0,
//    addressBus 16'h0, inputDataBus 0, rsp_rdata 0, rsp_err 0, last_grant=1 (req0 wins first).
//  - FSM: IDLE -> ISSUE -> [CAPTURE if read] -> DONE -> IDLE.
//  - IDLE: if any req_valid, pick winner; both valid -> the one not in last_grant; one valid ->
//    it. Pulse req_ready[win], latch write/addr/wdata, update last_grant, go ISSUE.
//  - ISSUE: addressBus = {MODULE_ID,4'h0,addr,4'h0}; exactly one of writeToMem/readFromMem
//    high for this single cycle; inputDataBus = wdata on write. Write -> DONE, read -> CAPTURE.
//  - CAPTURE: addressBus back to 16'h0 (memory deselected); sample outputDataBus at end of cycle.
//  - DONE: rsp_valid[win]=1 one cycle; rsp_rdata updated on reads only; go IDLE.
//  - Latency from req_ready cycle (T0): write rsp_valid at T2, read rsp_valid at T3.
//    Back-to-back throughput: write every 3 cycles, read every 4.
//  - req_valid while busy: ignored (req_ready low); requester keeps waiting. A dropped
//    req_valid before acceptance is legal and leaves no state.
//  - Never both strobes high; strobes never high outside ISSUE.
//  - Reset mid-operation: access aborted, no rsp_valid for it, strobes low from next cycle.
// CONFIGURATION
//  MEM_ARB_RANGE_CHECK_EN defined: addr >= MEM_DEPTH is accepted but no strobe issued;
//    ISSUE -> DONE with rsp_err=1, rsp_rdata=0 (same T2 latency, both reads and writes).
//  Not defined: address passed to addressBus unchanged, rsp_err tied 0, no range logic.
// STRUCTURE
//  mem_arb_pkg: state enum (IDLE, ISSUE, CAPTURE, DONE); module-select codes
//    (instruction 4'h0, memory 4'h1, ALU 4'h2, EXE 4'h3, register 4'h4); DATA_W/MEM_AW defaults.
//  Sub-module mem_arb_rr_pick: 2-way round-robin picker (req_valid, last_grant -> grant, any).
// TESTING
//  1 req0 read addr 0 alone -> req_ready=01 T0, readFromMem T1 with addressBus 16'h1000,
//    rsp_valid=01 T3, rsp_rdata = memory word 0 reset contents.
//  2 req1 write addr 2 data 256'hA5..A5 then req0 read addr 2 -> writeToMem T1 addr 16'h1020,
//    later read returns 256'hA5..A5.
//  3 req0 and req1 valid same cycle, repeatedly -> grants alternate 01,10,01,10; no starvation.
//  4 request held during busy -> req_ready stays 0 until IDLE; exactly one strobe per access.
//  5 read addr 4'h9: RANGE_CHECK_EN -> no strobe, rsp_err=1, rsp_rdata 0 at T2; undefined ->
//    readFromMem with addressBus 16'h1090, rsp_err=0.
//  6 reset low during CAPTURE -> no rsp_valid, all outputs at reset values next cycle, next
//    simultaneous request granted to req0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the matrix-memory access arbiter.
// Holds the FSM state enum, the module-select codes used on addressBus[15:12],
// the default widths, and a helper that builds the memory address bus word.
package mem_arb_pkg;

  localparam int DEF_DATA_W    = 256;
  localparam int DEF_MEM_AW    = 4;
  localparam int DEF_MEM_DEPTH = 8;

  // Module-select codes driven on addressBus[15:12]
  localparam logic [3:0] SEL_INSTR    = 4'h0;
  localparam logic [3:0] SEL_MEMORY   = 4'h1;
  localparam logic [3:0] SEL_ALU      = 4'h2;
  localparam logic [3:0] SEL_EXE      = 4'h3;
  localparam logic [3:0] SEL_REGISTER = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } mem_arb_state_e;

  // Bus word: {module select, 4'h0, word address, 4'h0}
  function automatic logic [15:0] mem_arb_addr_bus(input logic [3:0] sel,
                                                   input logic [3:0] addr);
    return {sel, 4'h0, addr, 4'h0};
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker. When both requesters are valid the one that
// did not win last time is granted; a lone requester always wins.
// last_grant_i = index of the previous winner.
module mem_arb_rr_pick (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       any_o
);

  // One-hot grant from the valid vector and previous winner
  always_comb begin
    grant_o = 2'b00;
    case (req_valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign any_o = |req_valid_i;

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the 8 x 256-bit matrix memory between req0 (EXE operand fetch) and
// req1 (ALU result writeback). Round-robin, one access in flight, all outputs
// registered.
//
// Optional feature: define MEM_ARB_RANGE_CHECK_EN to reject addresses
// >= MEM_DEPTH (no strobe, rsp_err=1, rsp_rdata=0, two-cycle response).
//
// Handshake: a requester holds req_valid with stable fields until it sees its
// one-cycle req_ready pulse; a completion is a one-cycle rsp_valid pulse to the
// same requester with rsp_rdata/rsp_err valid alongside it.
//
// Timing, relative to the req_ready cycle T0: strobe cycle T1, read data
// returned by the memory in T2, rsp_valid at T2 (write/error) or T3 (read).
// The state register runs one cycle ahead of the registered outputs: ISSUE
// prepares the strobe, CAPTURE waits out the strobe cycle, DONE samples the
// memory and prepares the response.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         DATA_W    = DEF_DATA_W,
  parameter int         MEM_AW    = DEF_MEM_AW,
  parameter int         MEM_DEPTH = DEF_MEM_DEPTH,
  parameter logic [3:0] MODULE_ID = SEL_MEMORY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*MEM_AW-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [15:0]         addressBus,
  output logic                writeToMem,
  output logic                readFromMem,
  output logic [DATA_W-1:0]   inputDataBus,
  input  logic [DATA_W-1:0]   outputDataBus,
  output logic                busy,
  output logic [1:0]          dbg_state_o
);

  mem_arb_state_e      state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                win_q, win_d;
  logic                wr_q, wr_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          req_ready_q, req_ready_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [15:0]         addr_bus_q, addr_bus_d;
  logic                write_q, write_d;
  logic                read_q, read_d;
  logic [DATA_W-1:0]   in_data_q, in_data_d;
  logic                busy_q, busy_d;

  logic [1:0]          pick_grant;
  logic                pick_any;
  logic                win_idx;
  logic                in_range;

  mem_arb_rr_pick u_pick (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .any_o        (pick_any)
  );

  assign win_idx = pick_grant[1];

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam logic [MEM_AW:0] DEPTH_L = (MEM_AW+1)'(MEM_DEPTH);
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
`else
  assign in_range = 1'b1;
`endif

  // Next-state and next-output computation for the access sequence
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    addr_bus_d   = 16'h0000;
    write_d      = 1'b0;
    read_d       = 1'b0;
    in_data_d    = in_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready_d  = pick_grant;
          win_d        = win_idx;
          last_grant_d = win_idx;
          wr_d         = req_write[win_idx];
          addr_d       = req_addr[win_idx*MEM_AW +: MEM_AW];
          wdata_d      = req_wdata[win_idx*DATA_W +: DATA_W];
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (in_range) begin
          addr_bus_d = mem_arb_addr_bus(MODULE_ID, addr_q);
          if (wr_q) begin
            write_d   = 1'b1;
            in_data_d = wdata_q;
          end else begin
            read_d = 1'b1;
          end
        end
        state_d = (wr_q || !in_range) ? ST_DONE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Strobe cycle is on the bus now; memory answers next cycle
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid_d[win_q] = 1'b1;
        if (!in_range) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          rsp_err_d = 1'b0;
          if (!wr_q) rsp_rdata_d = outputDataBus;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      addr_bus_q   <= 16'h0000;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      in_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      addr_bus_q   <= addr_bus_d;
      write_q      <= write_d;
      read_q       <= read_d;
      in_data_q    <= in_data_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign addressBus   = addr_bus_q;
  assign writeToMem   = write_q;
  assign readFromMem  = read_q;
  assign inputDataBus = in_data_q;
  assign busy         = busy_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: an 8-word memory model on the memory side,
// two requesters driven from tables and $urandom, and a cycle-level reference
// model built from the arbitration and latency rules (round-robin winner,
// response 2 or 3 cycles after accept, single strobe the cycle after accept).
// Honours MEM_ARB_RANGE_CHECK_EN when the DUT is built with it.
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_write;
  logic [7:0]   req_addr;
  logic [511:0] req_wdata;
  logic [1:0]   req_ready, rsp_valid;
  logic [255:0] rsp_rdata, inputDataBus, outputDataBus;
  logic         rsp_err, writeToMem, readFromMem, busy;
  logic [15:0]  addressBus;
  logic [1:0]   dbg_state;

  mem_access_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addressBus(addressBus), .writeToMem(writeToMem), .readFromMem(readFromMem),
    .inputDataBus(inputDataBus), .outputDataBus(outputDataBus), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [255:0] init_word(input int i);
    return {32{8'(8'h30 + i)}};
  endfunction

  // Memory model: reloads its contents while reset is low, read data one cycle after strobe
  logic [255:0] mem [8];
  logic [255:0] mem_rd;
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= init_word(i);
      mem_rd <= '0;
    end else begin
      if (writeToMem && addressBus[15:12] == 4'h1 && !addressBus[7])
        mem[addressBus[6:4]] <= inputDataBus;
      if (readFromMem)
        mem_rd <= (addressBus[15:12] == 4'h1 && !addressBus[7]) ? mem[addressBus[6:4]] : '0;
    end
  end
  assign outputDataBus = mem_rd;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int free_c   = 0;
  logic         last_g;
  logic [255:0] last_rdata;
  logic [255:0] ref_mem [8];
  logic [255:0] exp_q[$];
  int           rsp_cyc_q[$];
  logic         rsp_win_q[$];
  logic         err_q[$];
  int           st_cyc;
  logic         st_wr;
  logic [15:0]  st_ab;
  logic [255:0] st_wd;

  // requester driver state
  logic         p_valid [2];
  logic         p_write [2];
  logic [3:0]   p_addr  [2];
  logic [255:0] p_data  [2];
  logic         rnd_en = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_g     = 1'b1;
    last_rdata = '0;
    free_c     = cyc;
    st_cyc     = -1;
    exp_q.delete(); rsp_cyc_q.delete(); rsp_win_q.delete(); err_q.delete();
    for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
  endtask

  // Reference model: evaluated at each negedge for the values the DUT sampled at the last posedge
  task automatic model_check();
    logic [1:0]   er;
    int           w;
    logic [3:0]   a;
    logic         wr, oor, err, ew, ee;
    logic [255:0] d, ed;
    int           lat;
    er = 2'b00;
    if (!reset) begin
      check("rst_ready",   256'(req_ready), 256'(0));
      check("rst_rspv",    256'(rsp_valid), 256'(0));
      check("rst_rdata",   rsp_rdata, '0);
      check("rst_err",     256'(rsp_err), 256'(0));
      check("rst_addrbus", 256'(addressBus), 256'(0));
      check("rst_wstrobe", 256'(writeToMem), 256'(0));
      check("rst_rstrobe", 256'(readFromMem), 256'(0));
      check("rst_indata",  inputDataBus, '0);
      check("rst_busy",    256'(busy), 256'(0));
      check("rst_state",   256'(dbg_state), 256'(ST_IDLE));
      model_reset();
    end else begin
      if ((cyc - 1) >= free_c && req_valid != 2'b00) begin
        if (req_valid == 2'b11) w = last_g ? 0 : 1;
        else                    w = req_valid[1] ? 1 : 0;
        last_g = (w == 1);
        er[w]  = 1'b1;
        a   = req_addr[w*4 +: 4];
        wr  = req_write[w];
        d   = req_wdata[w*256 +: 256];
        oor = (a >= 4'd8);
`ifdef MEM_ARB_RANGE_CHECK_EN
        err = oor;
`else
        err = 1'b0;
`endif
        if (err)       ed = '0;
        else if (wr)   ed = last_rdata;
        else           ed = oor ? '0 : ref_mem[a[2:0]];
        if (wr && !oor && !err) ref_mem[a[2:0]] = d;
        last_rdata = ed;
        lat = (wr || err) ? 2 : 3;
        rsp_cyc_q.push_back(cyc + lat);
        rsp_win_q.push_back(w == 1);
        exp_q.push_back(ed);
        err_q.push_back(err);
        free_c = cyc + lat;
        st_cyc = err ? -1 : cyc + 1;
        st_wr  = wr;
        st_ab  = {4'h1, 4'h0, a, 4'h0};
        st_wd  = d;
      end
      check("req_ready", 256'(req_ready), 256'(er));
      if (rsp_cyc_q.size() != 0 && rsp_cyc_q[0] == cyc) begin
        void'(rsp_cyc_q.pop_front());
        ew = rsp_win_q.pop_front();
        ed = exp_q.pop_front();
        ee = err_q.pop_front();
        check("rsp_valid", 256'(rsp_valid), ew ? 256'(2) : 256'(1));
        check("rsp_rdata", rsp_rdata, ed);
        check("rsp_err",   256'(rsp_err), 256'(ee));
      end else begin
        check("rsp_valid_idle", 256'(rsp_valid), 256'(0));
      end
      if (cyc == st_cyc) begin
        check("writeToMem",  256'(writeToMem), 256'(st_wr));
        check("readFromMem", 256'(readFromMem), 256'(!st_wr));
        check("addressBus",  256'(addressBus), 256'(st_ab));
        if (st_wr) check("inputDataBus", inputDataBus, st_wd);
      end else begin
        check("wstrobe_idle", 256'(writeToMem), 256'(0));
        check("rstrobe_idle", 256'(readFromMem), 256'(0));
        check("addrbus_idle", 256'(addressBus), 256'(0));
      end
      check("busy", 256'(busy), 256'(cyc < free_c));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply();
    req_valid = {p_valid[1], p_valid[0]};
    req_write = {p_write[1], p_write[0]};
    req_addr  = {p_addr[1], p_addr[0]};
    req_wdata = {p_data[1], p_data[0]};
  endtask

  task automatic post(input int i, input logic wr, input logic [3:0] a, input logic [255:0] d);
    p_valid[i] = 1'b1; p_write[i] = wr; p_addr[i] = a; p_data[i] = d;
    apply();
  endtask

  task automatic new_req(input int i);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
    p_valid[i] = 1'b1;
    p_write[i] = 1'($urandom_range(0, 1));
    p_addr[i]  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
    p_data[i]  = d;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    model_check();
    for (int i = 0; i < 2; i++) if (p_valid[i] && req_ready[i]) p_valid[i] = 1'b0;
    if (rnd_en) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i]) begin
          if ($urandom_range(0, 2) == 0) new_req(i);
        end else if ($urandom_range(0, 29) == 0) begin
          p_valid[i] = 1'b0;
        end
      end
    end
    apply();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((p_valid[0] || p_valid[1] || rsp_cyc_q.size() != 0 || cyc < free_c) && n < 60) begin
      step();
      n++;
    end
    check("idle_timeout", 256'(n >= 60), 256'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 1'b0; p_write[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
    end
    reset = 1'b0;
    apply();
    model_reset();
    repeat (3) step();
    reset = 1'b1;

    // read word 0 from reset contents
    post(0, 1'b0, 4'd0, '0);
    wait_idle();
    // req1 writes A5.. to word 2, req0 reads it back
    post(1, 1'b1, 4'd2, {32{8'hA5}});
    wait_idle();
    post(0, 1'b0, 4'd2, '0);
    wait_idle();
    // simultaneous requests alternate between requesters
    for (int r = 0; r < 4; r++) begin
      post(0, 1'b0, 4'($urandom_range(0, 7)), '0);
      post(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), {8{$urandom()}});
      wait_idle();
    end
    // out-of-range read and write
    post(0, 1'b0, 4'd9, '0);
    wait_idle();
    post(1, 1'b1, 4'd12, {32{8'h3C}});
    wait_idle();

    // randomized traffic with holds and drops
    rnd_en = 1'b1;
    repeat (500) step();
    rnd_en = 1'b0;
    for (int i = 0; i < 2; i++) p_valid[i] = 1'b0;
    apply();
    wait_idle();

    // reset in the middle of a read, then a simultaneous request
    post(0, 1'b0, 4'd1, '0);
    n = 0;
    while (p_valid[0] && n < 20) begin
      step();
      n++;
    end
    check("t6_accept", 256'(p_valid[0]), 256'(0));
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    post(0, 1'b0, 4'd3, '0);
    post(1, 1'b0, 4'd4, '0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net if the stimulus ever stalls
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=stalled exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
